// File: rtl/conv1d_pkg.sv
// Shared opcodes, FSM state encodings and helpers for the conv1d engine.
package conv1d_pkg;

    localparam int CMD_W  = 7;
    localparam int WORD_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_MAC   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    localparam logic [CMD_W-1:0] OP_RD_BUF  = 7'd0;
    localparam logic [CMD_W-1:0] OP_WR_IN   = 7'd1;
    localparam logic [CMD_W-1:0] OP_WR_KERN = 7'd2;
    localparam logic [CMD_W-1:0] OP_OFFSET  = 7'd3;
    localparam logic [CMD_W-1:0] OP_BIAS    = 7'd4;
    localparam logic [CMD_W-1:0] OP_DEPTH   = 7'd5;
    localparam logic [CMD_W-1:0] OP_START   = 7'd6;
    localparam logic [CMD_W-1:0] OP_RD_ACC  = 7'd7;
    localparam logic [CMD_W-1:0] OP_START_X = 7'd8;
    localparam logic [CMD_W-1:0] OP_STATUS  = 7'd9;
    localparam logic [CMD_W-1:0] OP_INFO    = 7'd10;
    localparam logic [CMD_W-1:0] OP_RB_IN   = 7'd11;
    localparam logic [CMD_W-1:0] OP_RB_KERN = 7'd12;

    function automatic logic [WORD_W-1:0] sext8(input logic [7:0] v);
        return {{(WORD_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/conv1d_if.sv
// Command/response bus of the conv1d engine; the host drives via master, the engine sits on slave.
interface conv1d_if;
    import conv1d_pkg::*;

    logic              en;
    logic [CMD_W-1:0]  cmd;
    logic [WORD_W-1:0] inp0;
    logic [WORD_W-1:0] inp1;
    logic [WORD_W-1:0] ret;
    logic              output_buffer_valid;

    modport master (
        output en, cmd, inp0, inp1,
        input  ret, output_buffer_valid
    );

    modport slave (
        input  en, cmd, inp0, inp1,
        output ret, output_buffer_valid
    );

endinterface

// File: rtl/conv1d_mac_lanes.sv
// LANES parallel int8 x (int8 + offset) multipliers feeding a binary adder tree (combinational).
module conv1d_mac_lanes #(
    parameter int LANES     = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic [LANES-1:0][7:0]       kern_i,
    input  logic [LANES-1:0][7:0]       x_i,
    input  logic signed [31:0]          offset_i,
    output logic signed [ACC_WIDTH-1:0] sum_o
);

    logic signed [31:0]          prod [LANES];
    // Heap-ordered tree: leaves at LANES..2*LANES-1, root at 1.
    logic signed [ACC_WIDTH-1:0] node [1:2*LANES-1];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = 32'($signed(kern_i[i])) * (32'($signed(x_i[i])) + offset_i);
            node[LANES+i] = ACC_WIDTH'(prod[i]);
        end
        for (int j = LANES - 1; j >= 1; j--) begin
            node[j] = node[2*j] + node[2*j+1];
        end
        sum_o = node[1];
    end

endmodule

// File: rtl/conv1d_engine.sv
// Command-driven 1-D convolution engine: int8 ring buffer x kernel, LANES MACs per cycle.
// Define CONV1D_READBACK_EN to add opcodes 11/12 (input/kernel buffer readback).
module conv1d_engine
    import conv1d_pkg::*;
#(
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int LANES              = 8,
    parameter int ACC_WIDTH          = 32
) (
    input  logic    clk,
    input  logic    reset,
    conv1d_if.slave bus
);

    localparam int BUF = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int IW  = (BUF > 1) ? $clog2(BUF) : 1;
    localparam int AW  = IW + 1;

    state_t                      state_q, state_d;
    logic [AW-1:0]               k_q, k_d;
    logic [AW-1:0]               base_q, base_d;
    logic [AW-1:0]               s_q, s_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] lane_sum;
    logic signed [ACC_WIDTH-1:0] partial_p1_q;
    logic                        vld_p1_q, vld_p1_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;
    logic signed [31:0]          bias_q, bias_d;
    logic signed [31:0]          offset_q, offset_d;
    logic [31:0]                 depth_q, depth_d;
    logic [31:0]                 start_x_q, start_x_d;
    logic [31:0]                 ret_q, ret_d;
    logic                        obv_q;

    logic signed [7:0]           in_mem   [BUF];
    logic signed [7:0]           kern_mem [BUF];

    logic                        busy, addr_ok, depth_ok, start_req;
    logic                        in_we, kern_we;
    logic [LANES-1:0][7:0]       lane_k, lane_x;

    // base+k+i never exceeds 2S-2, so one conditional subtract wraps the ring.
    function automatic logic [IW-1:0] ring_addr(input logic [AW-1:0] sum, input logic [AW-1:0] s);
        return IW'((sum >= s) ? sum - s : sum);
    endfunction

    assign busy     = (state_q != ST_IDLE);
    assign addr_ok  = (bus.inp0 < 32'(BUF));
    assign depth_ok = (depth_q != 32'd0) && (depth_q <= 32'(MAX_INPUT_CHANNELS));

    // Stage p0: lane operand fetch, each lane wrapping independently.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_k[i] = '0;
            lane_x[i] = '0;
            if (state_q == ST_MAC) begin
                lane_k[i] = kern_mem[IW'(k_q + AW'(i))];
                lane_x[i] = in_mem[ring_addr(base_q + k_q + AW'(i), s_q)];
            end
        end
    end

    conv1d_mac_lanes #(
        .LANES     (LANES),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lanes (
        .kern_i   (lane_k),
        .x_i      (lane_x),
        .offset_i (offset_q),
        .sum_o    (lane_sum)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        s_d       = s_q;
        acc_d     = acc_q;
        vld_p1_d  = 1'b0;
        done_d    = done_q;
        error_d   = error_q;
        bias_d    = bias_q;
        offset_d  = offset_q;
        depth_d   = depth_q;
        start_x_d = start_x_q;
        ret_d     = ret_q;
        in_we     = 1'b0;
        kern_we   = 1'b0;
        start_req = 1'b0;

        if (bus.en) begin
            case (bus.cmd)
                OP_RD_BUF:  ret_d = 32'(BUF);
                OP_WR_IN:   in_we   = !busy && addr_ok;
                OP_WR_KERN: kern_we = !busy && addr_ok;
                OP_OFFSET:  if (!busy) offset_d  = bus.inp1;
                OP_BIAS:    if (!busy) bias_d    = bus.inp1;
                OP_DEPTH:   if (!busy) depth_d   = bus.inp1;
                OP_START:   start_req = !busy;
                OP_RD_ACC:  ret_d = acc_q[31:0];
                OP_START_X: if (!busy) start_x_d = bus.inp1;
                OP_STATUS:  ret_d = {30'b0, error_q, done_q};
                OP_INFO:    ret_d = {16'(LANES), 16'(KERNEL_LENGTH)};
`ifdef CONV1D_READBACK_EN
                OP_RB_IN:   ret_d = addr_ok ? sext8(in_mem[bus.inp0[IW-1:0]]) : '0;
                OP_RB_KERN: ret_d = addr_ok ? sext8(kern_mem[bus.inp0[IW-1:0]]) : '0;
`endif
                default:    ret_d = '0;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    acc_d  = ACC_WIDTH'(bias_q);
                    done_d = !depth_ok;
                    error_d = !depth_ok;
                    if (depth_ok) begin
                        k_d     = '0;
                        // (start_x*depth) mod (KL*depth) == depth*(start_x mod KL): no divider by depth.
                        base_d  = AW'((start_x_q % 32'(KERNEL_LENGTH)) * depth_q);
                        s_d     = AW'(32'(KERNEL_LENGTH) * depth_q);
                        state_d = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                if (vld_p1_q) acc_d = acc_q + partial_p1_q;
                vld_p1_d = 1'b1;
                k_d      = k_q + AW'(LANES);
                if (k_q == s_q - AW'(LANES)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                acc_d   = acc_q + partial_p1_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            base_q    <= '0;
            s_q       <= '0;
            acc_q     <= '0;
            vld_p1_q  <= 1'b0;
            done_q    <= 1'b1;
            error_q   <= 1'b0;
            bias_q    <= '0;
            offset_q  <= '0;
            depth_q   <= '0;
            start_x_q <= '0;
            ret_q     <= '0;
            obv_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            s_q       <= s_d;
            acc_q     <= acc_d;
            vld_p1_q  <= vld_p1_d;
            done_q    <= done_d;
            error_q   <= error_d;
            bias_q    <= bias_d;
            offset_q  <= offset_d;
            depth_q   <= depth_d;
            start_x_q <= start_x_d;
            ret_q     <= ret_d;
            obv_q     <= 1'b1;
        end
    end

    // Stage p1: lane sum register; vld_p1_q says whether acc should absorb it.
    always_ff @(posedge clk) begin
        partial_p1_q <= lane_sum;
    end

    always_ff @(posedge clk) begin
        if (in_we)   in_mem[bus.inp0[IW-1:0]]   <= bus.inp1[7:0];
        if (kern_we) kern_mem[bus.inp0[IW-1:0]] <= bus.inp1[7:0];
    end

    assign bus.ret                 = ret_q;
    assign bus.output_buffer_valid = obv_q;

endmodule

// File: tb/tb_conv1d_engine.sv
// Scoreboard bench for conv1d_engine: directed commands push expected ret values, a monitor pops them.
module tb_conv1d_engine;
    import conv1d_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv1d_if bus();

    conv1d_engine #(
        .KERNEL_LENGTH      (8),
        .MAX_INPUT_CHANNELS (128),
        .LANES              (8),
        .ACC_WIDTH          (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic        chk_req;
    logic        chk_q;
    int          checks   = 0;
    int          failures = 0;

    // ret is registered, so an expectation issued this cycle is due one edge later.
    always @(posedge clk) chk_q <= chk_req;

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        string       t;
        if (chk_q === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow got=%08h", bus.ret);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (bus.ret !== e) begin
                    failures++;
                    $display("FAIL %s got=%08h want=%08h", t, bus.ret, e);
                end
            end
        end
    end

    task automatic cmd_op(input logic [6:0] c, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.en = 1'b1; bus.cmd = c; bus.inp0 = a; bus.inp1 = v; chk_req = 1'b0;
    endtask

    task automatic rd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] e, input string t);
        @(negedge clk);
        bus.en = 1'b1; bus.cmd = c; bus.inp0 = a; bus.inp1 = '0; chk_req = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic rd_noen(input logic [6:0] c, input logic [31:0] e, input string t);
        @(negedge clk);
        bus.en = 1'b0; bus.cmd = c; bus.inp0 = '0; bus.inp1 = '0; chk_req = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.en = 1'b0; chk_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.en = 1'b0; bus.cmd = '0; bus.inp0 = '0; bus.inp1 = '0;
        chk_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checks++;
        if (bus.output_buffer_valid !== 1'b1) begin
            failures++;
            $display("FAIL obv_after_reset got=%0b want=1", bus.output_buffer_valid);
        end

        rd(OP_STATUS, 0, 32'h1, "rst_status");
        rd(OP_RD_ACC, 0, 32'h0, "rst_acc");
        rd(OP_RD_BUF, 0, 32'd1024, "buf_size");
        rd(OP_INFO, 0, 32'h0008_0008, "info");
        rd(7'd13, 0, 32'h0, "unknown_op");

        // Basic run: depth 1, kernel all 1, input all 2 -> 16, done two cycles after start.
        for (int j = 0; j < 8; j++) begin
            cmd_op(OP_WR_KERN, 32'(j), 32'd1);
            cmd_op(OP_WR_IN, 32'(j), 32'd2);
        end
        cmd_op(OP_DEPTH, 0, 32'd1);
        cmd_op(OP_START, 0, 0);
        rd(OP_STATUS, 0, 32'h0, "A_busy1");
        rd(OP_STATUS, 0, 32'h0, "A_busy2");
        rd(OP_STATUS, 0, 32'h1, "A_done");
        rd(OP_RD_ACC, 0, 32'd16, "A_acc");

        // Accumulator overflow wraps.
        cmd_op(OP_BIAS, 0, 32'h7FFF_FFFF);
        cmd_op(OP_START, 0, 0);
        idle(3);
        rd(OP_RD_ACC, 0, 32'h8000_000F, "A_wrap");
        rd_noen(OP_RD_BUF, 32'h8000_000F, "en_low_holds_ret");

        // Offset cancels input; busy writes must be ignored.
        cmd_op(OP_BIAS, 0, 32'd0);
        cmd_op(OP_OFFSET, 0, 32'd128);
        cmd_op(OP_DEPTH, 0, 32'd2);
        for (int j = 0; j < 16; j++) begin
            cmd_op(OP_WR_KERN, 32'(j), 32'd1);
            cmd_op(OP_WR_IN, 32'(j), 32'h0000_0080);
        end
        cmd_op(OP_START, 0, 0);
        cmd_op(OP_WR_KERN, 0, 32'd5);
        rd(OP_STATUS, 0, 32'h0, "B_busy_status1");
        rd(OP_STATUS, 0, 32'h0, "B_busy_status2");
        rd(OP_STATUS, 0, 32'h1, "B_done");
        rd(OP_RD_ACC, 0, 32'h0, "B_acc_zero");

        cmd_op(OP_BIAS, 0, 32'hFFFF_FFFB);
        cmd_op(OP_START, 0, 0);
        cmd_op(OP_BIAS, 0, 32'd100);
        idle(3);
        rd(OP_RD_ACC, 0, 32'hFFFF_FFFB, "B_bias_neg5");

        // 16 * (1 * -128) + (-5): kernel[0] and bias unchanged by the busy writes.
        cmd_op(OP_OFFSET, 0, 32'd0);
        cmd_op(OP_START, 0, 0);
        idle(4);
        rd(OP_RD_ACC, 0, 32'hFFFF_F7FB, "B_kernel_bias_untouched");

        // Out-of-range writes must not alias onto kernel[0] / input[6].
        cmd_op(OP_WR_KERN, 32'd1024, 32'd50);
        cmd_op(OP_WR_IN, 32'd1030, 32'd100);
        cmd_op(OP_BIAS, 0, 32'd0);
        cmd_op(OP_DEPTH, 0, 32'd1);
        for (int j = 0; j < 16; j++) begin
            cmd_op(OP_WR_IN, 32'(j), 32'(j));
            cmd_op(OP_WR_KERN, 32'(j), (j == 0) ? 32'd1 : 32'd0);
        end
        cmd_op(OP_START_X, 0, 32'd6);
        cmd_op(OP_START, 0, 0);
        idle(3);
        rd(OP_RD_ACC, 0, 32'd6, "C_start_x6");
        cmd_op(OP_START_X, 0, 32'd9);
        cmd_op(OP_START, 0, 0);
        idle(3);
        rd(OP_RD_ACC, 0, 32'd1, "C_start_x9_wrap");

        // Depth 2, base 14: lane 3 wraps to input[1] inside the first group -> 14 + 1.
        cmd_op(OP_WR_KERN, 32'd3, 32'd1);
        cmd_op(OP_DEPTH, 0, 32'd2);
        cmd_op(OP_START_X, 0, 32'd7);
        cmd_op(OP_START, 0, 0);
        idle(4);
        rd(OP_RD_ACC, 0, 32'd15, "C_lane_straddle");

        // Invalid depths.
        cmd_op(OP_BIAS, 0, 32'd7);
        cmd_op(OP_DEPTH, 0, 32'd0);
        cmd_op(OP_START, 0, 0);
        rd(OP_STATUS, 0, 32'h3, "D_depth0_status");
        rd(OP_RD_ACC, 0, 32'd7, "D_depth0_acc");
        cmd_op(OP_BIAS, 0, 32'hFFFF_FFFF);
        cmd_op(OP_DEPTH, 0, 32'd129);
        cmd_op(OP_START, 0, 0);
        rd(OP_STATUS, 0, 32'h3, "D_depth129_status");
        rd(OP_RD_ACC, 0, 32'hFFFF_FFFF, "D_depth129_acc");

        // Valid start clears error: -1 + input[7] + input[2] = 8.
        cmd_op(OP_DEPTH, 0, 32'd1);
        cmd_op(OP_START, 0, 0);
        idle(3);
        rd(OP_STATUS, 0, 32'h1, "D_error_cleared");
        rd(OP_RD_ACC, 0, 32'd8, "D_recovered_acc");

        // Asynchronous reset during MAC.
        cmd_op(OP_DEPTH, 0, 32'd2);
        cmd_op(OP_START, 0, 0);
        @(negedge clk);
        bus.en = 1'b0; chk_req = 1'b0;
        #2 reset = 1'b1;
        #4 reset = 1'b0;
        rd(OP_STATUS, 0, 32'h1, "E_reset_status");
        rd(OP_RD_ACC, 0, 32'h0, "E_reset_acc");
        cmd_op(OP_START, 0, 0);
        rd(OP_STATUS, 0, 32'h3, "E_depth_cleared");

`ifdef CONV1D_READBACK_EN
        cmd_op(OP_WR_IN, 32'd5, 32'h0000_00FD);
        rd(OP_RB_IN, 32'd5, 32'hFFFF_FFFD, "F_readback_input");
        rd(OP_RB_KERN, 32'd0, 32'h1, "F_readback_kernel");
        rd(OP_RB_KERN, 32'd2000, 32'h0, "F_readback_oor");
`else
        rd(OP_RB_IN, 32'd5, 32'h0, "F_op11_default");
        rd(OP_RB_KERN, 32'd0, 32'h0, "F_op12_default");
`endif

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv1d_engine.md
CONV1D_ENGINE -- requirements
Module: conv1d_engine

Interface
REQ-001 SHALL have parameter KERNEL_LENGTH, default 8, taps per filter (positive, multiple of LANES).
REQ-002 SHALL have parameter MAX_INPUT_CHANNELS, default 128, maximum input_depth.
REQ-003 SHALL have parameter LANES, default 8, MACs per cycle (power of two).
REQ-004 SHALL have parameter ACC_WIDTH, default 32, accumulator width (at least 32).
REQ-005 SHALL have clk  input  1  the only clock, rising-edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have en  input  1  command strobe; the block ignores cmd when en=0, but computation still advances.
REQ-008 SHALL have cmd  input  7  opcode.
REQ-009 SHALL have inp0  input  32  address.
REQ-010 SHALL have inp1  input  32  value.
REQ-011 SHALL have ret  output  32  response, registered, one cycle after the command.
REQ-012 SHALL have output_buffer_valid  output  1  held 1 after reset (response always valid).

Function
REQ-013 SHALL hold int8 input and kernel buffers, each BUF = KERNEL_LENGTH*MAX_INPUT_CHANNELS entries; input is a ring of size S = KERNEL_LENGTH*input_depth.
REQ-014 SHALL decode the opcodes: 0 ret<=BUF; 1 input[inp0]<=inp1[7:0]; 2 kernel[inp0]<=inp1[7:0]; 3 input_offset<=inp1; 4 bias<=inp1; 5 input_depth<=inp1; 6 start; 7 ret<=acc[31:0]; 8 start_x<=inp1; 9 ret<={30'b0,error,done}; 10 ret<={16'(LANES),16'(KERNEL_LENGTH)}; any other opcode ret<=0.
REQ-015 SHALL ignore opcode 1/2 writes with inp0>=BUF, with no state change.
REQ-016 SHALL use the FSM IDLE->MAC->DRAIN->IDLE; busy = state!=IDLE.
REQ-017 SHALL ignore opcodes 1,2,3,4,5,6,8 while busy; opcodes 7, 9 and 10 stay served.
REQ-018 On start in IDLE with 1<=input_depth<=MAX_INPUT_CHANNELS: SHALL set acc<=sign-extended bias, k<=0, base<=(start_x*input_depth) mod S, done<=0, error<=0, and enter MAC.
REQ-019 On start with input_depth 0 or >MAX_INPUT_CHANNELS: SHALL set acc<=bias, error<=1, done<=1, and stay IDLE.
REQ-020 In MAC, SHALL compute each cycle lane i (0..LANES-1) as kernel[k+i]*(input[(base+k+i) mod S]+input_offset), with each product signed 32-bit.
REQ-021 In MAC, SHALL register the lane sum as partial, and set k<=k+LANES.
REQ-022 SHALL add partial into acc (pipeline depth 1); MAC exits to DRAIN after the cycle with k=S-LANES.
REQ-023 In DRAIN, SHALL add the last partial, set done<=1, and return to IDLE.
REQ-024 SHALL reach done S/LANES+1 cycles after the start cycle.
REQ-025 SHALL wrap the ring address per lane, so a LANES group may straddle the S boundary.
REQ-026 SHALL use two's-complement wrap on accumulator overflow, with no saturation.

Reset
REQ-027 On reset, SHALL set state=IDLE, done=1, error=0, acc=0, bias=0, input_offset=0, input_depth=0, start_x=0, ret=0, output_buffer_valid=1.
REQ-028 SHALL leave buffer contents undefined after reset; reset mid-MAC SHALL abort with done=1.

Configuration
REQ-029 With CONV1D_READBACK_EN defined: opcode 11 SHALL return ret<=sign-extended input[inp0], and opcode 12 SHALL return ret<=sign-extended kernel[inp0] (0 if inp0>=BUF).
REQ-030 Without CONV1D_READBACK_EN: opcodes 11 and 12 SHALL fall to default (ret<=0), and no buffer read port beyond the MAC lanes SHALL be built.

Structure
REQ-031 SHALL place the opcode localparams and the state enum in package conv1d_pkg.
REQ-032 SHALL use one sub-module, conv1d_mac_lanes: LANES multipliers plus adder tree, combinational, feeding the partial register.

Verification
REQ-033 depth=1, kernel all 1, input all 2, offset=0, bias=0, start_x=0 -> done after 2 cycles, acc=16.
REQ-034 depth=2, offset=128, kernel[j]=1, input[j]=-128 for all j -> acc=0; bias=-5 -> acc=-5.
REQ-035 depth=1, input[j]=j, kernel[0]=1 else 0, start_x=6 -> acc=6; start_x=9 (wrap) -> acc=1.
REQ-036 start with depth=0 -> status=3 (error, done) next cycle, acc=bias; depth=129 -> same.
REQ-037 cmd 2 write during busy -> kernel unchanged; cmd 9 during busy -> 0; after done -> 1.
REQ-038 reset asserted mid-MAC -> status=1 and acc=0 next read; READBACK_EN build: write input[5]=-3, cmd 11 addr 5 -> 0xFFFFFFFD.
